// File: rtl/deadlock_monitor_pkg.sv
// -----------------------------------------------------------------------------
// deadlock_monitor_pkg
// Shared defaults for the kernel deadlock monitors. It provides the default
// status-vector widths, the default freeze threshold, and a helper that sizes
// the stall counter for a given threshold.
// -----------------------------------------------------------------------------
package deadlock_monitor_pkg;

    localparam int DEF_N_AXIS    = 14;
    localparam int DEF_N_INST    = 3;
    localparam int DEF_N_IBLK    = 1;
    localparam int DEF_THRESHOLD = 1000;

    // The counter must be able to hold values 0..threshold.
    function automatic int cnt_width(input int threshold);
        return $clog2(threshold + 1);
    endfunction

endpackage

// File: rtl/deadlock_stall_counter.sv
// -----------------------------------------------------------------------------
// deadlock_stall_counter
// This module counts consecutive stalled cycles and flags the cycle on which
// the count reaches THRESHOLD.
//
// Ports:
//   clock   in   rising-edge clock
//   reset   in   synchronous active-high reset; clears the count
//   stall   in   kernel frozen and blocked this cycle
//   hold    in   freeze the count (deadlock already declared)
//   expired out  combinational; the count reaches THRESHOLD on this edge
// -----------------------------------------------------------------------------
module deadlock_stall_counter
    import deadlock_monitor_pkg::*;
#(
    parameter int THRESHOLD = DEF_THRESHOLD
) (
    input  logic clock,
    input  logic reset,
    input  logic stall,
    input  logic hold,
    output logic expired
);

    localparam int               CNT_W = cnt_width(THRESHOLD);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(THRESHOLD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (hold) begin
            cnt_d = cnt_q;
        end else if (stall) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end
    end

    // The count becomes THRESHOLD on this edge. After that, hold keeps the
    // count from moving, so it never passes THRESHOLD.
    assign expired = stall & ~hold & (cnt_q == LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/deadlock_idx0_monitor.sv
// -----------------------------------------------------------------------------
// deadlock_idx0_monitor
// This is the deadlock detector for kernel index 0. It asserts a sticky block
// flag once the kernel's status vector has stayed unchanged, with at least one
// blocking flag set, for THRESHOLD consecutive cycles.
//
// Ports:
//   clock            in   rising-edge clock
//   reset            in   synchronous active-high reset
//   axis_block_sigs  in   per-stream AXIS stalled flags   [N_AXIS]
//   inst_idle_sigs   in   per-instance ap_idle flags      [N_INST]
//   inst_block_sigs  in   per-instance blocked flags      [N_IBLK]
//   block            out  deadlock detected; registered, sticky until reset
// -----------------------------------------------------------------------------
module deadlock_idx0_monitor
    import deadlock_monitor_pkg::*;
#(
    parameter int N_AXIS    = DEF_N_AXIS,
    parameter int N_INST    = DEF_N_INST,
    parameter int N_IBLK    = DEF_N_IBLK,
    parameter int THRESHOLD = DEF_THRESHOLD
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_INST-1:0] inst_idle_sigs,
    input  logic [N_IBLK-1:0] inst_block_sigs,
    output logic              block
);

    localparam int VEC_W = N_AXIS + N_IBLK + N_INST;

    logic [VEC_W-1:0] vec;
    logic [VEC_W-1:0] prev_vec_q;
    logic             any_blk;
    logic             stall;
    logic             expired;
    logic             block_q;
    logic             block_d;

    // Idle flags are part of the vector, so an idle change breaks the freeze.
    // They never count as blocking.
    assign vec     = {axis_block_sigs, inst_block_sigs, inst_idle_sigs};
    assign any_blk = (|axis_block_sigs) | (|inst_block_sigs);

    // prev_vec resets to zero, and any_blk implies vec is nonzero. The first
    // blocked sample after reset or after a change therefore never counts.
    assign stall   = any_blk & (vec == prev_vec_q);

    deadlock_stall_counter #(
        .THRESHOLD (THRESHOLD)
    ) u_cnt (
        .clock   (clock),
        .reset   (reset),
        .stall   (stall),
        .hold    (block_q),
        .expired (expired)
    );

    assign block_d = block_q | expired;

    always_ff @(posedge clock) begin
        if (reset) begin
            prev_vec_q <= '0;
            block_q    <= 1'b0;
        end else begin
            prev_vec_q <= vec;
            block_q    <= block_d;
        end
    end

    assign block = block_q;

endmodule

// File: tb/tb_deadlock_idx0_monitor.sv
module tb_deadlock_idx0_monitor;

    logic        clock;
    logic        reset;
    logic [13:0] axis_block_sigs;
    logic [2:0]  inst_idle_sigs;
    logic [0:0]  inst_block_sigs;
    logic        blk8;
    logic        blk1;

    int n_chk;
    int n_err;

    typedef struct {
        string tag;
        logic  e8;
        logic  e1;
    } exp_t;

    exp_t sb_q[$];

    deadlock_idx0_monitor #(
        .N_AXIS(14), .N_INST(3), .N_IBLK(1), .THRESHOLD(8)
    ) u_dut8 (
        .clock           (clock),
        .reset           (reset),
        .axis_block_sigs (axis_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .inst_block_sigs (inst_block_sigs),
        .block           (blk8)
    );

    deadlock_idx0_monitor #(
        .N_AXIS(14), .N_INST(3), .N_IBLK(1), .THRESHOLD(1)
    ) u_dut1 (
        .clock           (clock),
        .reset           (reset),
        .axis_block_sigs (axis_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .inst_block_sigs (inst_block_sigs),
        .block           (blk1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk_eq(input string tag, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b", tag, act, exp);
        end
    endtask

    // Queue the expected block values for the coming edge. Then advance one
    // clock, sample 1 time unit after the edge, and retire the oldest entry.
    task automatic step(input string tag, input logic e8, input logic e1);
        exp_t e;
        e.tag = tag;
        e.e8  = e8;
        e.e1  = e1;
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        e = sb_q.pop_front();
        chk_eq({e.tag, "_t8"}, blk8, e.e8);
        chk_eq({e.tag, "_t1"}, blk1, e.e1);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        step(tag, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        axis_block_sigs = '0;
        inst_idle_sigs  = '0;
        inst_block_sigs = '0;

        // Reset state
        do_reset("rst0");

        // All inputs zero for 50 cycles
        for (int k = 0; k < 50; k++)
            step($sformatf("zero_k%0d", k), 1'b0, 1'b0);

        // Single AXIS flag held from E0, then released. Block stays sticky.
        axis_block_sigs = 14'h0001;
        for (int k = 0; k < 12; k++)
            step($sformatf("ax1_k%0d", k), k >= 8, k >= 1);
        axis_block_sigs = '0;
        for (int k = 0; k < 5; k++)
            step($sformatf("ax1_rel_k%0d", k), 1'b1, 1'b1);
        do_reset("rst1");

        // Idle flag change after edge 5: the first new sample is edge 6,
        // so block rises after edge 14.
        axis_block_sigs = 14'h0010;
        for (int k = 0; k < 6; k++)
            step($sformatf("tog_k%0d", k), 1'b0, k >= 1);
        inst_idle_sigs = 3'b100;
        for (int k = 6; k < 18; k++)
            step($sformatf("tog_k%0d", k), k >= 14, 1'b1);
        axis_block_sigs = '0;
        inst_idle_sigs  = '0;
        do_reset("rst2");

        // any_blk drops for one cycle (edge 6). It reasserts from edge 7,
        // so block rises after edge 15.
        axis_block_sigs = 14'h0100;
        for (int k = 0; k < 6; k++)
            step($sformatf("drop_k%0d", k), 1'b0, k >= 1);
        axis_block_sigs = '0;
        step("drop_k6", 1'b0, 1'b1);
        axis_block_sigs = 14'h0100;
        for (int k = 7; k < 17; k++)
            step($sformatf("drop_k%0d", k), k >= 15, 1'b1);
        axis_block_sigs = '0;
        do_reset("rst3");

        // Idle only, no blocking flags, for 100 cycles
        inst_idle_sigs = 3'b110;
        for (int k = 0; k < 100; k++)
            step($sformatf("idle_k%0d", k), 1'b0, 1'b0);
        inst_idle_sigs = '0;
        do_reset("rst4");

        // Instance blocking flag held. Reset is pulsed mid-hold.
        inst_block_sigs = 1'b1;
        for (int k = 0; k < 10; k++)
            step($sformatf("iblk_k%0d", k), k >= 8, k >= 1);
        do_reset("iblk_rst");
        for (int j = 1; j < 12; j++)
            step($sformatf("iblk_j%0d", j), j >= 9, j >= 2);
        inst_block_sigs = '0;
        do_reset("rst5");

        // Top AXIS bit with THRESHOLD=1
        axis_block_sigs = 14'h2000;
        for (int k = 0; k < 4; k++)
            step($sformatf("t1_k%0d", k), 1'b0, k >= 1);
        axis_block_sigs = '0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
